// File: rtl/fb_write_ctrl.sv
// Write-side sequencer for the RGB333 framebuffer BRAM: a full-frame clear/fill
// engine and a valid/ready streamed pixel loader, optionally confined to blanking.
module fb_write_ctrl #(
  parameter int FB_W       = 320,
  parameter int FB_H       = 240,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 9,
  parameter int BLANK_ONLY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear_req,
  input  logic [DATA_W-1:0] i_clear_color,
  input  logic              i_load_start,
  input  logic              i_abort,
  input  logic              i_blank,
  input  logic              i_pix_valid,
  input  logic [DATA_W-1:0] i_pix_data,
  output logic              o_pix_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr_wr,
  output logic [DATA_W-1:0] o_data_wr,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] clear_color;
  logic              permit;
  logic              wr_fire;
  logic [DATA_W-1:0] wr_data;

  assign permit      = (BLANK_ONLY == 0) || i_blank;
  assign o_pix_ready = (state == LOAD) && permit && !i_abort;
  assign o_busy      = (state != IDLE);

  // Both sources share one write path; abort suppresses the write in its cycle.
  always_comb begin
    wr_fire = 1'b0;
    wr_data = clear_color;
    if (state == CLEAR && !i_abort && permit) begin
      wr_fire = 1'b1;
    end else if (i_pix_valid && o_pix_ready) begin
      wr_fire = 1'b1;
      wr_data = i_pix_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      clear_color <= '0;
      o_we        <= 1'b0;
      o_addr_wr   <= '0;
      o_data_wr   <= '0;
      o_done      <= 1'b0;
    end else begin
      o_we   <= 1'b0;
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_clear_req) begin
            state       <= CLEAR;
            clear_color <= i_clear_color;
            addr        <= '0;
          end else if (i_load_start) begin
            state <= LOAD;
            addr  <= '0;
          end
        end
        CLEAR, LOAD: begin
          if (i_abort) begin
            state <= IDLE;
            addr  <= '0;
          end else if (wr_fire) begin
            o_we      <= 1'b1;
            o_addr_wr <= addr;
            o_data_wr <= wr_data;
            // The final pixel ends the frame in the same update as its write.
            if (addr == LAST_ADDR) begin
              o_done <= 1'b1;
              state  <= IDLE;
              addr   <= '0;
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          addr  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/fb_write_ctrl.md
Name: fb_write_ctrl

Overview:
Write-side controller for the 320x240x9-bit (RGB333) display framebuffer BRAM. It drives the BRAM write port (we, addr_wr, data_wr) and sequences two write sources: a hardware clear/fill engine and a streamed pixel loader with a valid/ready handshake (e.g. from a UART image receiver). It optionally restricts writes to display blanking so that the read side never sees a frame being torn. The display read path stays on the BRAM read port and is untouched.

Parameters:
FB_W, 320, framebuffer width in pixels
FB_H, 240, framebuffer height in pixels
ADDR_W, 17, BRAM address width (must hold FB_W*FB_H-1 = 76799)
DATA_W, 9, pixel width (RGB333)
BLANK_ONLY, 0, 1 = write only while i_blank=1; 0 = write any cycle

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
i_clear_req  in  1  1-cycle pulse; starts a full-frame fill
i_clear_color  in  DATA_W  fill colour; sampled when the clear is accepted
i_load_start  in  1  1-cycle pulse; starts a full-frame stream load
i_abort  in  1  return to IDLE; the operation does not complete
i_blank  in  1  display is in blanking (hblank or vblank)
i_pix_valid  in  1  loader pixel valid
i_pix_data  in  DATA_W  loader pixel, raster order
o_pix_ready  out  1  controller accepts a pixel this cycle
o_we  out  1  BRAM write enable (registered)
o_addr_wr  out  ADDR_W  BRAM write address (registered)
o_data_wr  out  DATA_W  BRAM write data (registered)
o_busy  out  1  state != IDLE
o_done  out  1  1-cycle pulse on the final write of a frame

Behaviour:
- States: IDLE, CLEAR, LOAD. Internal address counter addr, range 0..FB_W*FB_H-1.
- Reset values: state=IDLE, addr=0, o_we=0, o_addr_wr=0, o_data_wr=0, o_done=0. o_busy=0 and o_pix_ready=0 follow from IDLE.
- A reset asserted during an operation behaves the same as a reset at power-up. The partially written frame is left as is.
- permit = (BLANK_ONLY==0) || i_blank.
- IDLE:
  - i_clear_req=1 -> CLEAR; latch i_clear_color; addr=0.
  - Otherwise i_load_start=1 -> LOAD; addr=0.
  - If both fire in the same cycle, clear wins and the load request is dropped.
  - Start pulses that arrive outside IDLE are ignored.
- CLEAR: in each cycle with permit=1, register o_we=1, o_addr_wr=addr, o_data_wr=latched colour, then addr++. Cycles with permit=0 produce o_we=0 and addr holds.
- LOAD:
  - o_pix_ready = (state==LOAD) && permit && !i_abort. This is combinational.
  - A handshake is i_pix_valid && o_pix_ready.
  - On a handshake, the next cycle has o_we=1, o_addr_wr=addr, o_data_wr=i_pix_data, and addr++. Latency from accept to write is 1 cycle.
  - A cycle with no handshake produces o_we=0 in the next cycle.
- Final write: when the write for addr=FB_W*FB_H-1 is issued:
  - o_done=1 in the same cycle as that o_we.
  - State returns to IDLE in that same registered update, so o_busy=0 from the following cycle.
  - addr resets to 0. Addresses never wrap past 76799.
- i_abort=1 in CLEAR or LOAD:
  - Next cycle: state=IDLE, o_we=0, no o_done, addr=0.
  - A pixel offered in the abort cycle is not accepted.
  - i_abort in IDLE has no effect.
- o_we, o_addr_wr and o_data_wr are all driven from flops. o_addr_wr and o_data_wr hold their last values while o_we=0.
- o_pix_ready is 0 in IDLE and CLEAR.

Test Plan:
- Reset, then i_clear_req with colour 9'h1C0, BLANK_ONLY=0 -> exactly 76800 consecutive o_we cycles, addresses 0..76799, data 9'h1C0. o_done is high only with address 76799. o_busy falls on the next cycle.
- LOAD with i_pix_valid toggling every other cycle and data=addr[8:0] -> each write lands 1 cycle after its accept. Addresses are contiguous with no gaps or duplicates. o_done fires on address 76799.
- BLANK_ONLY=1, CLEAR with i_blank high 160 of every 800 cycles -> o_we=1 only in cycles following i_blank=1. The final address is still 76799.
- i_clear_req and i_load_start pulsed together in IDLE -> CLEAR runs. A later i_load_start while busy is ignored, and o_pix_ready stays 0 throughout.
- LOAD, abort after 1000 accepted pixels -> the last write is address 999. Next cycle o_busy=0 and o_done is never asserted. A new LOAD starts again at address 0.
- rst pulsed mid-CLEAR at address 5000 -> next cycle all outputs are at reset values and state is IDLE. A following clear starts at address 0.
